ir_key_event_ctrl: RTL

- Sits between the NEC IR receiver and the application logic.
- Turns the receiver's decoded-frame pulses (data_valid with key code) and repeat-frame pulses (repeat_en) into a stream of key events: PRESS, auto-REPEAT and RELEASE.
- Handles press tracking, auto-repeat pacing, release-by-timeout and back-to-back key changes.
- Buffers events in a small FIFO with a valid/ready handshake so slow consumers do not lose keys.

---
 rtl/ir_key_event_ctrl_if.sv | 10 +
 rtl/ir_key_event_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ir_key_event_ctrl_if.sv
// Key-event stream handshake: the controller presents the FIFO head, the consumer accepts it.
interface ir_key_event_ctrl_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_type;
    logic [7:0] evt_key;

    modport master (output evt_valid, output evt_type, output evt_key, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_type, input  evt_key, output evt_ready);
endinterface

// File: rtl/ir_key_event_ctrl.sv
// Turns NEC receiver frame/repeat pulses into PRESS / REPEAT / RELEASE key events,
// buffered in a small show-ahead FIFO with a valid/ready output.
module ir_key_event_ctrl #(
    parameter int unsigned HOLD_TIMEOUT = 6000000,
    parameter int unsigned RPT_DELAY    = 3,
    parameter int unsigned RPT_RATE     = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [19:0]          ir_data,
    input  logic                 ir_data_valid,
    input  logic                 ir_repeat_en,
    input  logic                 clr_overflow,
    output logic                 key_held,
    output logic [7:0]           held_key,
    output logic                 overflow,
    ir_key_event_ctrl_if.master  evt_if
);

    localparam int unsigned TMR_W   = $clog2(HOLD_TIMEOUT + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned EVT_W   = 10;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RT   = RPT_W'(RPT_RATE);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_PEND} state_t;

    state_t            state;
    logic [7:0]        pending;
    logic [TMR_W-1:0]  timer;
    logic [RPT_W-1:0]  rpt_cnt;

    logic              push_c;
    logic [1:0]        push_type_c;
    logic [7:0]        push_key_c;

    logic [EVT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              evt_valid;
    logic              pop_c;
    logic              wr_en_c;
    logic [CNT_W-1:0]  count_nxt_c;

    // Only the key code byte of the receiver word is meaningful here.
    logic unused_ir_data;
    assign unused_ir_data = ^ir_data[19:8];

    // Event to push this cycle; data_valid outranks repeat, at most one push.
    always_comb begin
        push_c      = 1'b0;
        push_type_c = EVT_PRESS;
        push_key_c  = held_key;
        case (state)
            S_IDLE: begin
                if (ir_data_valid) begin
                    push_c     = 1'b1;
                    push_key_c = ir_data[7:0];
                end
            end
            S_HELD: begin
                if (ir_data_valid) begin
                    push_c      = 1'b1;
                    push_type_c = EVT_RELEASE;
                end else if (ir_repeat_en) begin
                    if (rpt_cnt == RPT_W'(1)) begin
                        push_c      = 1'b1;
                        push_type_c = EVT_REPEAT;
                    end
                end else if (timer == TMR_LAST) begin
                    push_c      = 1'b1;
                    push_type_c = EVT_RELEASE;
                end
            end
            S_PEND: begin
                push_c     = 1'b1;
                push_key_c = ir_data_valid ? ir_data[7:0] : pending;
            end
            default: ;
        endcase
    end

    // Press tracking, repeat pacing and release-by-timeout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            pending  <= '0;
            timer    <= '0;
            rpt_cnt  <= '0;
            key_held <= 1'b0;
            held_key <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ir_data_valid) begin
                        held_key <= ir_data[7:0];
                        rpt_cnt  <= RPT_DLY;
                        timer    <= '0;
                        key_held <= 1'b1;
                        state    <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (ir_data_valid) begin
                        pending <= ir_data[7:0];
                        state   <= S_PEND;
                    end else if (ir_repeat_en) begin
                        timer   <= '0;
                        rpt_cnt <= (rpt_cnt == RPT_W'(1)) ? RPT_RT : rpt_cnt - RPT_W'(1);
                    end else if (timer == TMR_LAST) begin
                        timer    <= '0;
                        key_held <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_PEND: begin
                    pending  <= push_key_c;
                    held_key <= push_key_c;
                    rpt_cnt  <= RPT_DLY;
                    timer    <= '0;
                    state    <= S_HELD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A push coinciding with a pop always fits, even when the FIFO is full.
    assign pop_c       = evt_valid && evt_if.evt_ready;
    assign wr_en_c     = push_c && ((count != CNT_FULL) || pop_c);
    assign count_nxt_c = count + CNT_W'(wr_en_c) - CNT_W'(pop_c);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= {push_type_c, push_key_c};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt_c;
            evt_valid <= (count_nxt_c != '0);
            if (push_c && !wr_en_c) overflow <= 1'b1;
            else if (clr_overflow)  overflow <= 1'b0;
        end
    end

    assign evt_if.evt_valid = evt_valid;
    assign evt_if.evt_type  = mem[rd_ptr][9:8];
    assign evt_if.evt_key   = mem[rd_ptr][7:0];

endmodule
